// File: rtl/seq_divmod.sv
// Radix-2 restoring divider: one quotient bit per clock, valid/ready on both sides.
// Produces quotient and remainder together; a zero divisor short-circuits to DONE.
module seq_divmod #(
   parameter int data_width = 16,
   parameter int cnt_width  = $clog2(data_width) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] A,
   input  logic [data_width-1:0] B,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] Q,
   output logic [data_width-1:0] R,
   output logic                  div_zero,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [cnt_width-1:0]  cnt_q, cnt_d;
   logic [data_width-1:0] rem_q, rem_d;
   logic [data_width-1:0] dvd_q, dvd_d;
   logic [data_width-1:0] div_q, div_d;
   logic [data_width-1:0] quo_q, quo_d;
   logic [data_width-1:0] res_r_q, res_r_d;
   logic                  dz_q, dz_d;

   logic [data_width:0]   rem_shift;
   logic                  sub_ok;
   logic [data_width-1:0] rem_next;
   logic [data_width-1:0] dvd_next;

   // Difference is always < divisor when sub_ok, so W-bit subtraction is exact.
   assign rem_shift = {rem_q, dvd_q[data_width-1]};
   assign sub_ok    = (rem_shift >= {1'b0, div_q});
   assign rem_next  = sub_ok ? (rem_shift[data_width-1:0] - div_q) : rem_shift[data_width-1:0];
   assign dvd_next  = {dvd_q[data_width-2:0], sub_ok};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      div_d   = div_q;
      quo_d   = quo_q;
      res_r_d = res_r_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               div_d = B;
               if (B != '0) begin
                  state_d = S_CALC;
                  cnt_d   = cnt_width'(data_width);
                  rem_d   = '0;
                  dvd_d   = A;
               end else begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  res_r_d = A;
                  dz_d    = 1'b1;
               end
            end
         end
         S_CALC: begin
            rem_d = rem_next;
            dvd_d = dvd_next;
            cnt_d = cnt_q - cnt_width'(1);
            if (cnt_q == cnt_width'(1)) begin
               state_d = S_DONE;
               quo_d   = dvd_next;
               res_r_d = rem_next;
               dz_d    = 1'b0;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         res_r_q <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         res_r_q <= res_r_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign Q         = quo_q;
   assign R         = res_r_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod: reset, nominal, boundaries, divide-by-zero,
// backpressure and reset abort, with hand-computed expected results.
module tb_seq_divmod;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Q;
   logic [15:0] R;
   logic        div_zero;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   seq_divmod #(.data_width(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Q(Q), .R(R), .div_zero(div_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one request, waits for the result, then lets it be consumed (out_ready assumed 1).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                         output logic [15:0] q, output logic [15:0] r, output logic dz,
                         output logic ov_after, output logic ir_after);
      @(negedge clk);
      in_valid = 1'b1; A = a; B = b;
      @(posedge clk); #1;
      in_valid = 1'b0; A = '0; B = '0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      q = Q; r = R; dz = div_zero;
      @(posedge clk); #1;
      ov_after = out_valid; ir_after = in_ready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (Q !== 16'd0) begin n_fail++; $display("FAIL reset_Q: got %0h want 0", Q); end
      n_checks++; if (R !== 16'd0) begin n_fail++; $display("FAIL reset_R: got %0h want 0", R); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
   endtask

   task automatic test_nominal();
      int lat; logic [15:0] q, r; logic dz, ova, ira;
      run_op(16'd100, 16'd7, lat, q, r, dz, ova, ira);
      n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL nominal_latency: got %0d want 16", lat); end
      n_checks++; if (q !== 16'd14) begin n_fail++; $display("FAIL nominal_Q: got %0d want 14", q); end
      n_checks++; if (r !== 16'd2) begin n_fail++; $display("FAIL nominal_R: got %0d want 2", r); end
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL nominal_div_zero: got %b want 0", dz); end
      n_checks++; if (ova !== 1'b0) begin n_fail++; $display("FAIL nominal_handoff_ov: got %b want 0", ova); end
      n_checks++; if (ira !== 1'b1) begin n_fail++; $display("FAIL nominal_handoff_ir: got %b want 1", ira); end
   endtask

   task automatic test_boundary();
      int lat; logic [15:0] q, r; logic dz, ova, ira;
      run_op(16'hFFFF, 16'd1, lat, q, r, dz, ova, ira);
      n_checks++; if (q !== 16'hFFFF || lat !== 16) begin n_fail++; $display("FAIL max_div1_Q: got %0h lat %0d want ffff lat 16", q, lat); end
      n_checks++; if (r !== 16'd0) begin n_fail++; $display("FAIL max_div1_R: got %0h want 0", r); end
      run_op(16'd5, 16'd9, lat, q, r, dz, ova, ira);
      n_checks++; if (q !== 16'd0) begin n_fail++; $display("FAIL a_lt_b_Q: got %0d want 0", q); end
      n_checks++; if (r !== 16'd5) begin n_fail++; $display("FAIL a_lt_b_R: got %0d want 5", r); end
      run_op(16'h8000, 16'h8000, lat, q, r, dz, ova, ira);
      n_checks++; if (q !== 16'd1) begin n_fail++; $display("FAIL a_eq_b_Q: got %0d want 1", q); end
      n_checks++; if (r !== 16'd0) begin n_fail++; $display("FAIL a_eq_b_R: got %0d want 0", r); end
   endtask

   task automatic test_div_zero();
      int lat; logic [15:0] q, r; logic dz, ova, ira;
      // DONE is entered on the accepting edge, so out_valid is up in the following cycle.
      run_op(16'h1234, 16'd0, lat, q, r, dz, ova, ira);
      n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dz_latency: got %0d extra edges want 0", lat); end
      n_checks++; if (q !== 16'hFFFF) begin n_fail++; $display("FAIL dz_Q: got %0h want ffff", q); end
      n_checks++; if (r !== 16'h1234) begin n_fail++; $display("FAIL dz_R: got %0h want 1234", r); end
      n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", dz); end
      run_op(16'd9, 16'd3, lat, q, r, dz, ova, ira);
      n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dz_clear_flag: got %b want 0", dz); end
      n_checks++; if (q !== 16'd3 || r !== 16'd0) begin n_fail++; $display("FAIL dz_follow_QR: got %0d/%0d want 3/0", q, r); end
      n_checks++; if (Q !== 16'd3 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_retain_Q: got %0d ov %b want 3 ov 0", Q, out_valid); end
   endtask

   task automatic test_backpressure();
      int lat; logic ir_ok, stable;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; A = 16'd50; B = 16'd6;
      @(posedge clk); #1;
      A = 16'd77; B = 16'd5;
      lat = 0; ir_ok = 1'b1;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) ir_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL bp_latency: got %0d want 16", lat); end
      n_checks++; if (ir_ok !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_calc: got %b want 1 (in_ready low)", ir_ok); end
      n_checks++; if (Q !== 16'd8 || R !== 16'd2) begin n_fail++; $display("FAIL bp_QR: got %0d/%0d want 8/2", Q, R); end
      stable = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (Q !== 16'd8 || R !== 16'd2 || out_valid !== 1'b1 || in_ready !== 1'b0 || div_zero !== 1'b0) stable = 1'b0;
      end
      n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b want 1 (stable)", stable); end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_handoff: ov %b ir %b busy %b want 0 1 0", out_valid, in_ready, busy); end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: busy %b ir %b want 1 0", busy, in_ready); end
      in_valid = 1'b0; A = '0; B = '0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++; if (Q !== 16'd15 || R !== 16'd2 || lat !== 16) begin n_fail++; $display("FAIL bp_second_QR: got %0d/%0d lat %0d want 15/2 lat 16", Q, R, lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat; logic [15:0] q, r; logic dz, ova, ira, seen;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; A = 16'd1000; B = 16'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; A = '0; B = '0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: busy %b ir %b ov %b want 0 1 0", busy, in_ready, out_valid); end
      n_checks++; if (Q !== 16'd0 || R !== 16'd0) begin n_fail++; $display("FAIL mid_reset_QR: got %0d/%0d want 0/0", Q, R); end
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_result: got %b want 0", seen); end
      run_op(16'd1000, 16'd3, lat, q, r, dz, ova, ira);
      n_checks++; if (q !== 16'd333 || r !== 16'd1) begin n_fail++; $display("FAIL after_reset_QR: got %0d/%0d want 333/1", q, r); end
      n_checks++; if (lat !== 16 || dz !== 1'b0) begin n_fail++; $display("FAIL after_reset_lat: got %0d dz %b want 16 dz 0", lat, dz); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_boundary();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
